// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master write sequencer.
//   i2c_state_e   : sequencer states IDLE/START/BIT/ACK/STOP
//   Q0..Q3        : quarter-phase indices within one bit slot
//   I2C_RW_WRITE  : R/W bit appended to the device address
//   I2C_FRAME_BYTES: bytes per write frame (address, register, data)
//   i2c_drive()   : SCL / SDA-pull level for a given state, quarter and bit
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_RW_WRITE    = 1'b0;
  localparam int   I2C_FRAME_BYTES = 3;

  typedef struct packed {
    logic scl;
    logic sda_oe;
  } i2c_bus_t;

  // Bus levels for one quarter. SDA only moves while SCL is low, except for
  // the deliberate START (q2) and STOP (q2) transitions with SCL high.
  function automatic i2c_bus_t i2c_drive(i2c_state_e st, logic [1:0] ph, logic bit_val);
    i2c_bus_t b;
    b.scl    = 1'b1;
    b.sda_oe = 1'b0;
    case (st)
      ST_START: begin
        b.scl    = (ph != Q3);
        b.sda_oe = (ph == Q2) || (ph == Q3);
      end
      ST_BIT: begin
        b.scl    = ph[1];
        b.sda_oe = ~bit_val;
      end
      ST_ACK: begin
        b.scl    = ph[1];
      end
      ST_STOP: begin
        b.scl    = (ph != Q0);
        b.sda_oe = (ph == Q0) || (ph == Q1);
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase for the I2C write sequencer.
//   clk, reset : system clock, async active-high reset
//   clr        : synchronous clear (frame accept) -> counter and phase to 0
//   tick       : high on the last clk cycle of each quarter
//   nxt_tick   : high when the following cycle will be a tick cycle
//   phase      : quarter index 0..3, advances after each tick
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  output logic       tick,
  output logic       nxt_tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign tick  = (cnt_q == LAST);
  assign phase = phase_q;
  // Lookahead lets the parent register a flag that lines up with a tick cycle.
  assign nxt_tick = (CLK_DIV == 1) ? 1'b1 : (!clr && (cnt_q == PRE));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_writer.sv
// I2C master write sequencer: one START / addr+W / ACK / reg / ACK / data /
// ACK / STOP frame per accepted start pulse.
//   clk, reset        : system clock, async active-high reset (releases bus)
//   start             : frame request, only looked at while IDLE
//   dev_addr/mem_addr/wr_data : frame contents, latched on accept
//   sda_i             : SDA readback for ACK sampling
//   scl, sda_oe       : bus drive (sda_oe=1 pulls SDA low)
//   busy, done        : frame in progress / one-cycle end-of-frame pulse
//   ack_err           : NACK seen in the last frame (sticky to next accept)
// Build option I2C_MASTER_ACK_CHECK_EN: sample ACKs, flag NACK and abort to
// STOP. Without it, sda_i is ignored, ack_err stays 0 and frames are fixed.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] mem_byte_q, mem_byte_d;
  logic [7:0] data_byte_q, data_byte_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       nack_q, nack_d;

  logic       accept, tick, nxt_tick, last_byte;
  logic [1:0] phase, phase_nxt;
  i2c_bus_t   drv;

  assign accept = (state_q == ST_IDLE) && start;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .tick     (tick),
    .nxt_tick (nxt_tick),
    .phase    (phase)
  );

`ifdef I2C_MASTER_ACK_CHECK_EN
  assign last_byte = (byte_idx_q == 2'(I2C_FRAME_BYTES - 1)) || nack_q;
`else
  logic unused_sda_i;
  assign unused_sda_i = sda_i;
  assign last_byte    = (byte_idx_q == 2'(I2C_FRAME_BYTES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    shreg_d     = shreg_q;
    mem_byte_d  = mem_byte_q;
    data_byte_d = data_byte_q;
    busy_d      = busy_q;
    ack_err_d   = ack_err_q;
    nack_d      = nack_q;
    phase_nxt   = tick ? phase + 2'd1 : phase;

    if (accept) begin
      shreg_d     = {dev_addr, I2C_RW_WRITE};
      mem_byte_d  = mem_addr;
      data_byte_d = wr_data;
      bit_cnt_d   = 3'd0;
      byte_idx_d  = 2'd0;
      busy_d      = 1'b1;
      ack_err_d   = 1'b0;
      nack_d      = 1'b0;
      state_d     = ST_START;
      phase_nxt   = Q0;
    end else if (tick) begin
      case (state_q)
        ST_START: if (phase == Q3) state_d = ST_BIT;
        ST_BIT: begin
          if (phase == Q3) begin
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
        end
        ST_ACK: begin
`ifdef I2C_MASTER_ACK_CHECK_EN
          // Sample on the last cycle of q2, mid SCL-high.
          if (phase == Q2 && sda_i) begin
            nack_d    = 1'b1;
            ack_err_d = 1'b1;
          end
`endif
          if (phase == Q3) begin
            if (last_byte) begin
              state_d = ST_STOP;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
              shreg_d    = (byte_idx_q == 2'd0) ? mem_byte_q : data_byte_q;
              bit_cnt_d  = 3'd0;
              state_d    = ST_BIT;
            end
          end
        end
        ST_STOP: if (phase == Q3) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // done lands on the final cycle of STOP q3; the state is still STOP then,
    // so a start in the done cycle is not accepted.
    done_d = (state_q == ST_STOP) && nxt_tick &&
             ((phase == Q3 && !tick) || (phase == Q2 && tick));
    if (done_d) busy_d = 1'b0;

    // Outputs are precomputed from the next state so they switch on the
    // first cycle of each quarter.
    drv      = i2c_drive(state_d, phase_nxt, shreg_d[7]);
    scl_d    = drv.scl;
    sda_oe_d = drv.sda_oe;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      shreg_q     <= 8'd0;
      mem_byte_q  <= 8'd0;
      data_byte_q <= 8'd0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      mem_byte_q  <= mem_byte_d;
      data_byte_q <= data_byte_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      nack_q      <= nack_d;
    end
  end

  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Self-checking bench for i2c_master_writer: slot-level frame model, slave
// ACK/NACK model on sda_i, bus decoder, per-cycle output comparison.
module tb_i2c_master_writer;

  localparam int CD = 4;
  localparam int QC = 4 * CD;   // cycles per bit slot
`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] mem_addr = '0, wr_data = '0;
  logic       sda_i, scl, sda_oe, busy, done, ack_err;

  int checks = 0, errors = 0;

  i2c_master_writer #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr),
    .mem_addr(mem_addr), .wr_data(wr_data), .sda_i(sda_i), .scl(scl),
    .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame = slots of 4 quarters: slot 0 START, then per byte 8 bit slots and
  // one ACK slot, final slot STOP.
  logic            m_active = 1'b0, m_ack_err = 1'b0;
  int              m_k = 0, m_n = 0, m_frames = 0;
  logic [2:0][7:0] m_bytes = '0;
  logic [2:0]      m_nack = '0, nack_req = '0;

  function automatic int frame_cycles(input logic [2:0] nk);
    if (ACK_CHK)
      for (int b = 0; b < 3; b++) if (nk[b]) return (9 * b + 11) * QC;
    return 29 * QC;
  endfunction

  function automatic logic [1:0] bus_at(input int k, input int n, input logic [2:0][7:0] by);
    int slot, q, s;
    slot = k / QC; q = (k / CD) % 4;
    if (slot == 0)          return (q == 3) ? 2'b01 : (q == 2) ? 2'b11 : 2'b10;
    if (slot == n / QC - 1) return (q == 0) ? 2'b01 : (q == 1) ? 2'b11 : 2'b10;
    s = slot - 1;
    if (s % 9 == 8) return {q >= 2, 1'b0};
    return {q >= 2, ~by[s / 9][7 - s % 9]};
  endfunction

  function automatic logic in_ack(input int k, input int n, input logic [2:0] nk, input bit want_nack);
    int slot, s;
    slot = k / QC;
    if (slot == 0 || slot >= n / QC - 1) return 1'b0;
    s = slot - 1;
    return (s % 9 == 8) && (nk[s / 9] == want_nack);
  endfunction

  // Slave pulls SDA low for the whole ACK slot of every byte it accepts.
  assign sda_i = ~(sda_oe | (m_active & in_ack(m_k, m_n, m_nack, 1'b0)));

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_active = 1'b0;
      m_ack_err = 1'b0;
    end else if (m_active) begin
      if (ACK_CHK && in_ack(m_k, m_n, m_nack, 1'b1) && (m_k % QC == 3 * CD - 1))
        m_ack_err = 1'b1;
      if (m_k == m_n - 1) m_active = 1'b0;
      else m_k++;
    end else if (start) begin
      m_bytes   = {wr_data, mem_addr, {dev_addr, 1'b0}};
      m_nack    = nack_req;
      m_n       = frame_cycles(nack_req);
      m_k       = 0;
      m_active  = 1'b1;
      m_ack_err = 1'b0;
      m_frames++;
    end
  end

  // ---------------- bus decoder + per-cycle compare ----------------
  int              mon_seen = 0, mon_nbits = 0, starts = 0, stops = 0;
  logic [2:0][7:0] mon_bytes = '0, mon_last = '0;
  logic            prev_scl = 1'b1, prev_sda = 1'b1;

  initial forever begin
    logic [4:0] e;
    int nb;
    @(negedge clk);
    if (!reset) begin
      if (m_frames != mon_seen) begin
        mon_seen = m_frames; mon_nbits = 0; starts = 0; stops = 0; mon_bytes = '0;
      end
      if (prev_scl && scl && prev_sda && !sda_i) starts++;
      if (prev_scl && scl && !prev_sda && sda_i) stops++;
      if (!prev_scl && scl && mon_nbits < 27) begin
        if (mon_nbits % 9 < 8) mon_bytes[mon_nbits / 9][7 - mon_nbits % 9] = sda_i;
        mon_nbits++;
      end
      prev_scl = scl; prev_sda = sda_i;

      if (m_active) e = {bus_at(m_k, m_n, m_bytes), m_k < m_n - 1, m_k == m_n - 1, m_ack_err};
      else          e = {2'b10, 2'b00, m_ack_err};
      chk("outputs{scl,sda_oe,busy,done,ack_err}", int'({scl, sda_oe, busy, done, ack_err}), int'(e));

      if (m_active && m_k == m_n - 1) begin
        nb = (m_n / QC - 2) / 9;
        chk("decoded_bits", mon_nbits, 9 * nb);
        for (int b = 0; b < nb; b++) chk("decoded_byte", int'(mon_bytes[b]), int'(m_bytes[b]));
        chk("start_cond", starts, 1);
        chk("stop_cond", stops, 1);
        mon_last = mon_bytes;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [6:0] d, input logic [7:0] m, input logic [7:0] w);
    @(posedge clk); #1;
    dev_addr = d; mem_addr = m; wr_data = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int extra, output int cyc, output int nd);
    cyc = 0; nd = 0;
    for (int i = 0; i < 3000 && nd == 0; i++) begin
      @(negedge clk);
      if (busy || done) cyc++;
      if (done) nd++;
    end
    if (nd == 0) chk("done_timeout", 0, 1);
    repeat (extra) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    int cyc, nd;
    #2 reset = 1'b1;
    #1 chk("reset_async", int'({scl, sda_oe, busy, done, ack_err}), 'b10000);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Nominal frame.
    nack_req = 3'b000;
    send(7'h50, 8'h12, 8'hA5);
    wait_done(4, cyc, nd);
    chk("nom_cycles", cyc, 464);
    chk("nom_done_count", nd, 1);
    chk("nom_ack_err", int'(ack_err), 0);
    chk("nom_byte0", int'(mon_last[0]), 'hA0);
    chk("nom_byte1", int'(mon_last[1]), 'h12);
    chk("nom_byte2", int'(mon_last[2]), 'hA5);

    // Slave NACKs: address only with ACK checking, everything without.
    nack_req = ACK_CHK ? 3'b001 : 3'b111;
    send(7'h50, 8'h12, 8'hA5);
    wait_done(4, cyc, nd);
    chk("nack_cycles", cyc, ACK_CHK ? 176 : 464);
    chk("nack_done_count", nd, 1);
    chk("nack_ack_err", int'(ack_err), ACK_CHK ? 1 : 0);
    chk("nack_byte0", int'(mon_last[0]), 'hA0);

    // Start pulse with new data while byte 1 is on the bus.
    nack_req = 3'b000;
    send(7'h50, 8'h12, 8'hA5);
    repeat (13 * QC) @(posedge clk);
    #1 dev_addr = 7'h7F; mem_addr = 8'hFF; wr_data = 8'hFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(4, cyc, nd);
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_byte1", int'(mon_last[1]), 'h12);
    chk("busy_start_byte2", int'(mon_last[2]), 'hA5);

    // Reset during byte 1, then a fresh frame.
    send(7'h50, 8'h12, 8'hA5);
    repeat (13 * QC) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("reset_mid", int'({scl, sda_oe, busy, done, ack_err}), 'b10000);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    send(7'h50, 8'h34, 8'h5A);
    wait_done(4, cyc, nd);
    chk("post_reset_cycles", cyc, 464);
    chk("post_reset_done_count", nd, 1);
    chk("post_reset_byte0", int'(mon_last[0]), 'hA0);
    chk("post_reset_byte1", int'(mon_last[1]), 'h34);
    chk("post_reset_byte2", int'(mon_last[2]), 'h5A);

    // start held high: second frame begins the cycle after done.
    @(posedge clk); #1;
    dev_addr = 7'($urandom); mem_addr = 8'($urandom); wr_data = 8'($urandom); start = 1'b1;
    wait_done(0, cyc, nd);
    dev_addr = 7'($urandom); mem_addr = 8'($urandom); wr_data = 8'($urandom);
    wait_done(0, cyc, nd);
    start = 1'b0;
    chk("b2b_second_cycles", cyc, 464);
    repeat (4) @(negedge clk);

    // Randomised frames.
    for (int i = 0; i < 6; i++) begin
      nack_req = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      send(7'($urandom), 8'($urandom), 8'($urandom));
      wait_done($urandom_range(0, 3), cyc, nd);
      chk("rand_cycles", cyc, frame_cycles(nack_req));
      chk("rand_done_count", nd, 1);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_writer.md
# i2c_master_writer

I2C master write sequencer that drives the bus into the slave FSM. On a `start` pulse it emits one complete write frame: START, device address with R/W=0, ACK slot, memory-address byte, ACK slot, data byte, ACK slot, STOP. It sits directly upstream of the slave state tracker and generates the SCL/SDA waveforms that the tracker decodes. SDA is open-drain: it is pulled low only while `sda_oe`=1.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period. Must be ≥1.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request pulse; sampled only in IDLE
- `dev_addr`  in  7  slave address; latched on accept
- `mem_addr`  in  8  memory/register byte; latched on accept
- `wr_data`  in  8  data byte; latched on accept
- `sda_i`  in  1  bus SDA readback, used for ACK sampling
- `scl`  out  1  SCL, push-pull
- `sda_oe`  out  1  1 = pull SDA low; 0 = release SDA (high)
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at end of frame
- `ack_err`  out  1  NACK seen in the last frame; sticky until the next accept

## Operation
- Reset values:
  - `scl`=1, `sda_oe`=0
  - `busy`=0, `done`=0, `ack_err`=0
  - state IDLE; quarter counter, bit counter and byte index all 0
- Accept: in IDLE with `start`=1:
  - latch byte0={`dev_addr`,1'b0}, byte1=`mem_addr`, byte2=`wr_data`
  - clear `ack_err`
  - `busy`=1 from the next cycle
- `start` while busy is ignored. Latched bytes never change mid-frame.
- States: IDLE → START → BIT → ACK → (BIT for the next byte | STOP) → IDLE.
- Each non-IDLE state spends four quarters (q0..q3) per bit.
- START, `scl`/`sda_oe` per quarter:
  - q0, q1: 1/0
  - q2: 1/1
  - q3: 0/1
- BIT, MSB first, 8 per byte:
  - q0, q1: `scl`=0, `sda_oe`=~bit
  - q2, q3: `scl`=1, SDA held
- ACK: `sda_oe`=0 throughout; `scl` is 0 in q0–q1 and 1 in q2–q3. `sda_i` is sampled on the last cycle of q2.
- After ACK:
  - byte index <2: go to BIT with the next byte
  - byte index =2: go to STOP
- STOP, `scl`/`sda_oe` per quarter:
  - q0: 0/1
  - q1: 1/1
  - q2, q3: 1/0
- After STOP q3: `done`=1 for one cycle, `busy`=0 in the same cycle, state returns to IDLE.
- A `start` present in that same cycle is not accepted. The earliest accept is the following cycle.
- Reset mid-frame: the bus is released immediately (asynchronously). No STOP is generated; the bench tolerates the glitch.

## Timing
- The quarter counter runs 0..CLK_DIV-1. A quarter ends when it reaches CLK_DIV-1. The counter is cleared on accept.
- Full frame = 4 + 27×4 + 4 = 116 quarters.
- With CLK_DIV=4 that is 464 cycles from the first busy cycle to the `done` cycle inclusive.
- Outputs are registered and change on the first cycle of each quarter.
- SCL frequency = f_clk / (4·CLK_DIV).

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined:
  - `sda_i`=1 at an ACK sample sets `ack_err`=1.
  - The FSM goes straight to STOP, skipping remaining bytes.
  - `done` still pulses at the end.
- Undefined:
  - `sda_i` is ignored and `ack_err` is tied to 0.
  - All three bytes are always sent, giving a fixed 116-quarter frame.

## Structure
- Package `i2c_pkg`:
  - state encoding (IDLE, START, BIT, ACK, STOP)
  - quarter-phase constants Q0..Q3
  - `I2C_RW_WRITE`=1'b0
  - frame byte count 3
- One sub-module, `i2c_quarter_tick`:
  - parameterised by CLK_DIV
  - sync clear on accept
  - outputs a one-cycle `tick` and a 2-bit `phase`
- The FSM, shift register and output registers live in the top module.

## Test plan
- Reset: assert `reset` mid-cycle → `scl`=1, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0 immediately (asynchronously).
- Nominal write, CLK_DIV=4:
  - stimulus: dev 0x50, mem 0x12, data 0xA5, slave model ACKs all
  - response: bytes on bus 0xA0, 0x12, 0xA5; START then STOP edges correct
  - response: `busy` for 464 cycles, single `done`, `ack_err`=0
- Macro on, slave NACKs the address:
  - response: `ack_err`=1 and STOP directly after the first ACK slot
  - response: frame is 44 quarters (176 cycles), then `done`
- Macro off, slave NACKs everything → full 116-quarter frame, `ack_err`=0.
- Pulse `start` with data 0xFF during byte 1 → bus still carries the original 0xA5; exactly one `done`.
- Reset during byte 1, then a new start (0x50/0x34/0x5A) → clean frame 0xA0, 0x34, 0x5A with correct timing.
